// File: rtl/sm_imem_loader_if.sv
// Bus bundle between the program-load host / CPU fetch port and sm_imem_loader.
// Signals:
//   imAddr    host->loader  CPU instruction word address
//   imData    loader->host  instruction word returned to CPU (combinational read)
//   ld_start  host->loader  one-cycle pulse that begins or restarts a load
//   ld_valid  host->loader  ld_data holds a valid byte
//   ld_data   host->loader  load stream byte
//   ld_ready  loader->host  loader accepts a byte this cycle
//   cpu_rst_n loader->host  active-low reset for the CPU
//   ld_busy   loader->host  load in progress
//   ld_done   loader->host  last load completed (sticky)
//   ld_err    loader->host  last load rejected (sticky)
interface sm_imem_loader_if;

    logic [31:0] imAddr;
    logic [31:0] imData;
    logic        ld_start;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_ready;
    logic        cpu_rst_n;
    logic        ld_busy;
    logic        ld_done;
    logic        ld_err;

    // Loader side
    modport slave (
        input  imAddr,
        input  ld_start,
        input  ld_valid,
        input  ld_data,
        output imData,
        output ld_ready,
        output cpu_rst_n,
        output ld_busy,
        output ld_done,
        output ld_err
    );

    // Host / CPU side
    modport master (
        output imAddr,
        output ld_start,
        output ld_valid,
        output ld_data,
        input  imData,
        input  ld_ready,
        input  cpu_rst_n,
        input  ld_busy,
        input  ld_done,
        input  ld_err
    );

endinterface

// File: rtl/sm_imem_loader.sv
// Instruction memory with a byte-stream program loader.
// A load is a 16-bit big-endian word count N followed by 4*N bytes, each
// 32-bit word assembled little-endian and written to consecutive addresses
// from 0. The CPU is held in reset while a load runs or after a rejected
// length, and released one cycle after a successful load completes.
// Ports:
//   clk    single clock, rising edge
//   rst_n  asynchronous active-low reset (memory contents are kept)
//   bus    sm_imem_loader_if.slave: fetch port, load stream and status
module sm_imem_loader #(
    parameter int unsigned SIZE = 64,
    parameter int unsigned AW   = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sm_imem_loader_if.slave      bus
);

    localparam int unsigned WW = 32;   // memory word width
    localparam int unsigned BW = 8;    // stream byte width
    localparam int unsigned NW = 16;   // word-count width
    localparam int unsigned SW = 24;   // bytes held before a word is complete

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LEN  = 2'd1;
    localparam logic [1:0] DATA = 2'd2;
    localparam logic [1:0] ERR  = 2'd3;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    logic [1:0]    state_q,    state_d;
    logic [1:0]    byte_cnt_q, byte_cnt_d;
    logic [AW-1:0] ptr_q,      ptr_d;
    logic [BW-1:0] len_hi_q,   len_hi_d;
    logic [NW-1:0] n_q,        n_d;
    logic [SW-1:0] sh_q,       sh_d;
    logic          done_q,     done_d;
    logic          err_q,      err_d;
    logic          ready_q;
    logic          busy_q;
    logic          cpu_rst_n_q;

    logic [WW-1:0] mem_q [SIZE];

    logic          accept_c;
    logic          mem_we_c;
    logic [NW-1:0] len_word_c;
    logic          len_bad_c;
    logic          last_word_c;

    // A byte is consumed only while the loader is taking stream data and no
    // restart is requested in the same cycle.
    assign accept_c    = bus.ld_valid && !bus.ld_start &&
                         ((state_q == LEN) || (state_q == DATA));

    assign len_word_c  = {len_hi_q, bus.ld_data};
    assign len_bad_c   = (len_word_c == NW'(0)) || (32'(len_word_c) > 32'(SIZE));
    assign last_word_c = (NW'(ptr_q) == (n_q - NW'(1)));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath control
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        ptr_d      = ptr_q;
        len_hi_d   = len_hi_q;
        n_d        = n_q;
        sh_d       = sh_q;
        done_d     = done_q;
        err_d      = err_q;
        mem_we_c   = 1'b0;

        if (bus.ld_start) begin
            // Restart from any state; any partially assembled word is dropped.
            state_d    = LEN;
            byte_cnt_d = 2'd0;
            ptr_d      = '0;
            done_d     = 1'b0;
            err_d      = 1'b0;
        end else begin
            case (state_q)
                LEN: begin
                    if (accept_c) begin
                        if (byte_cnt_q == 2'd0) begin
                            len_hi_d   = bus.ld_data;
                            byte_cnt_d = 2'd1;
                        end else begin
                            n_d        = len_word_c;
                            byte_cnt_d = 2'd0;
                            ptr_d      = '0;
                            if (len_bad_c) begin
                                state_d = ERR;
                                err_d   = 1'b1;
                            end else begin
                                state_d = DATA;
                            end
                        end
                    end
                end

                DATA: begin
                    if (accept_c) begin
                        // Shift right so the first byte ends up in bits 7:0.
                        sh_d       = {bus.ld_data, sh_q[SW-1:BW]};
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            mem_we_c = 1'b1;
                            ptr_d    = ptr_q + AW'(1);
                            if (last_word_c) begin
                                state_d = IDLE;
                                done_d  = 1'b1;
                            end
                        end
                    end
                end

                ERR: begin
                    // Parked until a restart or reset.
                end

                default: begin
                    // IDLE: stream bytes are ignored.
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath and registered status outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt_q  <= 2'd0;
            ptr_q       <= '0;
            len_hi_q    <= '0;
            n_q         <= '0;
            sh_q        <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            cpu_rst_n_q <= 1'b0;
        end else begin
            byte_cnt_q  <= byte_cnt_d;
            ptr_q       <= ptr_d;
            len_hi_q    <= len_hi_d;
            n_q         <= n_d;
            sh_q        <= sh_d;
            done_q      <= done_d;
            err_q       <= err_d;
            ready_q     <= (state_d == LEN) || (state_d == DATA);
            busy_q      <= (state_d == LEN) || (state_d == DATA);
            // Release only after a full cycle in IDLE, so the CPU still sees
            // reset on the cycle ld_done first rises.
            cpu_rst_n_q <= (state_q == IDLE) && (state_d == IDLE);
        end
    end

    // ------------------------------------------------------------------
    // Instruction memory: no reset, survives rst_n and aborted loads
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem_q[ptr_q] <= {bus.ld_data, sh_q};
        end
    end

    // Asynchronous read returns the pre-write value during a write cycle;
    // out-of-range fetches return a nop.
    assign bus.imData    = (bus.imAddr < 32'(SIZE)) ? mem_q[bus.imAddr[AW-1:0]] : '0;

    assign bus.ld_ready  = ready_q;
    assign bus.ld_busy   = busy_q;
    assign bus.ld_done   = done_q;
    assign bus.ld_err    = err_q;
    assign bus.cpu_rst_n = cpu_rst_n_q;

endmodule

// File: tb/tb_sm_imem_loader.sv
// Self-checking bench for sm_imem_loader: directed scenarios plus randomized
// loads, compared against a word-level memory model built from the byte stream.
module tb_sm_imem_loader;

    localparam int unsigned SIZE = 64;

    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    sm_imem_loader_if bus ();

    sm_imem_loader #(.SIZE(SIZE), .AW(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0] m_mem   [SIZE];
    bit          m_known [SIZE];

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bq_t mk_stream(input int n_hdr, input int n_words);
        bq_t q;
        q.push_back(8'(n_hdr >> 8));
        q.push_back(8'(n_hdr));
        for (int i = 0; i < n_words * 4; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    // Restart pulse, optionally with a byte offered in the same cycle.
    task automatic pulse_start(input bit junk);
        bus.ld_start = 1'b1;
        bus.ld_valid = junk;
        bus.ld_data  = 8'($urandom);
        tick();
        bus.ld_start = 1'b0;
        bus.ld_valid = 1'b0;
        check1("start_ready", bus.ld_ready, 1'b1);
        check1("start_busy", bus.ld_busy, 1'b1);
        check1("start_cpu_rst_n", bus.cpu_rst_n, 1'b0);
        check1("start_done", bus.ld_done, 1'b0);
        check1("start_err", bus.ld_err, 1'b0);
    endtask

    // Send the first nsend bytes of stream s with random idle gaps; nsend never
    // exceeds the number of bytes the length header allows.
    task automatic send(input bq_t s, input int nsend, input int maxgap, output int acc);
        int nw;
        int total;
        int gap;
        int sent;
        bit ok;
        nw    = int'(s[0]) * 256 + int'(s[1]);
        ok    = (nw >= 1) && (nw <= int'(SIZE));
        total = ok ? 2 + 4 * nw : 2;
        acc   = 0;
        for (int k = 0; k < nsend; k++) begin
            gap = int'($urandom_range(maxgap, 0));
            for (int g = 0; g < gap; g++) begin
                bus.ld_valid = 1'b0;
                bus.ld_data  = 8'($urandom);
                #1;
                check1("gap_ready", bus.ld_ready, 1'b1);
                tick();
            end
            bus.ld_valid = 1'b1;
            bus.ld_data  = s[k];
            if (ok && k >= 2 && ((k - 2) % 4) == 3) begin
                int wi;
                wi = (k - 2) / 4;
                bus.imAddr = 32'(wi);
                #1;
                if (m_known[wi]) check("prewrite_read", bus.imData, m_mem[wi]);
            end else begin
                #1;
            end
            check1("byte_ready", bus.ld_ready, 1'b1);
            check1("byte_cpu_rst_n", bus.cpu_rst_n, 1'b0);
            check1("byte_busy", bus.ld_busy, 1'b1);
            if (bus.ld_valid === 1'b1 && bus.ld_ready === 1'b1) acc++;
            tick();
        end
        bus.ld_valid = 1'b0;
        sent = (nsend < total) ? nsend : total;
        if (ok && sent > 2) begin
            for (int i = 0; i < (sent - 2) / 4; i++) begin
                m_mem[i]   = {s[5 + 4*i], s[4 + 4*i], s[3 + 4*i], s[2 + 4*i]};
                m_known[i] = 1'b1;
            end
        end
    endtask

    // Offer bytes while the loader must refuse them.
    task automatic offer_junk(input int cycles);
        int acc;
        acc = 0;
        for (int c = 0; c < cycles; c++) begin
            bus.ld_valid = 1'b1;
            bus.ld_data  = 8'($urandom);
            #1;
            if (bus.ld_ready === 1'b1) acc++;
            tick();
        end
        bus.ld_valid = 1'b0;
        check("junk_accepted", 32'(acc), 32'd0);
    endtask

    task automatic sweep_mem();
        for (int a = 0; a < int'(SIZE); a++) begin
            if (m_known[a]) begin
                bus.imAddr = 32'(a);
                #1;
                check("mem_word", bus.imData, m_mem[a]);
                tick();
            end
        end
        bus.imAddr = 32'd64;
        #1;
        check("oob_64", bus.imData, 32'h0);
        bus.imAddr = 32'h0000_0100;
        #1;
        check("oob_256", bus.imData, 32'h0);
        bus.imAddr = 32'hFFFF_FFFF;
        #1;
        check("oob_max", bus.imData, 32'h0);
        tick();
    endtask

    initial begin
        bq_t s;
        bq_t s2;
        int  acc;
        int  nw;

        for (int i = 0; i < int'(SIZE); i++) begin
            m_known[i] = 1'b0;
            m_mem[i]   = 32'h0;
        end
        bus.imAddr   = 32'h0;
        bus.ld_start = 1'b0;
        bus.ld_valid = 1'b0;
        bus.ld_data  = 8'h00;
        rst_n        = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check1("rst_ready", bus.ld_ready, 1'b0);
        check1("rst_busy", bus.ld_busy, 1'b0);
        check1("rst_done", bus.ld_done, 1'b0);
        check1("rst_err", bus.ld_err, 1'b0);
        check1("rst_cpu_rst_n", bus.cpu_rst_n, 1'b0);
        rst_n = 1'b1;
        tick();
        check1("release_cpu_rst_n", bus.cpu_rst_n, 1'b1);
        check1("release_ready", bus.ld_ready, 1'b0);

        // Reference two-word load
        s = {8'h00, 8'h02, 8'h01, 8'h00, 8'h08, 8'h24, 8'h00, 8'h00, 8'h00, 8'h10};
        pulse_start(1'b0);
        send(s, 10, 0, acc);
        check("ref_accepted", 32'(acc), 32'd10);
        check1("ref_done", bus.ld_done, 1'b1);
        check1("ref_cpu_rst_n_hold", bus.cpu_rst_n, 1'b0);
        check1("ref_ready_off", bus.ld_ready, 1'b0);
        tick();
        check1("ref_cpu_rst_n_rise", bus.cpu_rst_n, 1'b1);
        bus.imAddr = 32'd1;
        #1;
        check("ref_word1", bus.imData, 32'h1000_0000);
        bus.imAddr = 32'd0;
        #1;
        check("ref_word0", bus.imData, 32'h2408_0001);
        tick();
        offer_junk(3);

        // Zero length rejected, then recovered by a valid load
        pulse_start(1'b1);
        s = {8'h00, 8'h00};
        send(s, 2, 0, acc);
        check1("zero_err", bus.ld_err, 1'b1);
        check1("zero_ready", bus.ld_ready, 1'b0);
        check1("zero_cpu_rst_n", bus.cpu_rst_n, 1'b0);
        repeat (3) tick();
        check1("zero_err_sticky", bus.ld_err, 1'b1);
        check1("zero_cpu_rst_n_hold", bus.cpu_rst_n, 1'b0);
        offer_junk(2);
        s = mk_stream(1, 1);
        pulse_start(1'b0);
        send(s, 6, 1, acc);
        check1("recover_done", bus.ld_done, 1'b1);
        check1("recover_err", bus.ld_err, 1'b0);
        tick();

        // Length one past the memory depth
        pulse_start(1'b0);
        s = {8'h00, 8'h41};
        send(s, 2, 0, acc);
        check1("over_err", bus.ld_err, 1'b1);
        check1("over_ready", bus.ld_ready, 1'b0);
        bus.imAddr = 32'd64;
        #1;
        check("over_oob", bus.imData, 32'h0);
        tick();

        // Three words with random stalls
        s = mk_stream(3, 3);
        pulse_start(1'b0);
        send(s, 14, 3, acc);
        check("gaps_accepted", 32'(acc), 32'd14);
        check1("gaps_done", bus.ld_done, 1'b1);
        offer_junk(4);

        // Restart after half a word
        s = mk_stream(1, 1);
        pulse_start(1'b0);
        send(s, 4, 0, acc);
        pulse_start(1'b1);
        s2 = mk_stream(1, 1);
        send(s2, 6, 0, acc);
        check1("restart_done", bus.ld_done, 1'b1);
        bus.imAddr = 32'd0;
        #1;
        check("restart_word0", bus.imData, {s2[5], s2[4], s2[3], s2[2]});
        tick();

        // Asynchronous reset mid-load
        s = mk_stream(4, 4);
        pulse_start(1'b0);
        send(s, 8, 1, acc);
        #3;
        rst_n = 1'b0;
        #1;
        check1("async_ready", bus.ld_ready, 1'b0);
        check1("async_busy", bus.ld_busy, 1'b0);
        check1("async_done", bus.ld_done, 1'b0);
        check1("async_err", bus.ld_err, 1'b0);
        check1("async_cpu_rst_n", bus.cpu_rst_n, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        check1("async_release", bus.cpu_rst_n, 1'b1);
        sweep_mem();

        // Randomized loads, the first one filling the whole memory
        for (int r = 0; r < 4; r++) begin
            nw = (r == 0) ? int'(SIZE) : int'($urandom_range(8, 1));
            s  = mk_stream(nw, nw);
            pulse_start(1'($urandom_range(1, 0)));
            send(s, 2 + 4 * nw, 2, acc);
            check("rand_accepted", 32'(acc), 32'(2 + 4 * nw));
            check1("rand_done", bus.ld_done, 1'b1);
            check1("rand_cpu_rst_n_hold", bus.cpu_rst_n, 1'b0);
            tick();
            check1("rand_cpu_rst_n_rise", bus.cpu_rst_n, 1'b1);
            offer_junk(2);
        end
        sweep_mem();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
